// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer
// Program counter and fetch controller for the 28-bit-instruction ROM.
// Drives the ROM address from the PC and samples the combinational ROM word.
// JMP and NOP are executed locally. Every other opcode is issued to the
// execute stage. After a BLE is issued, fetch waits until execute resolves it.
//
// Handshake: oValid marks oInstruction/oPC as meaningful. A word is accepted
// on a rising edge where oValid & !iStall. Until then, the issued word is held
// stable. slot_free = !oValid | !iStall means the output register may be
// overwritten at this edge.
module rom_fetch_sequencer #(
    parameter int              ADDR_W    = 16,
    parameter int              INSN_W    = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit              NOP_DELAY = 1'b1,
    parameter logic [3:0]      OP_NOP    = 4'd0,
    parameter logic [3:0]      OP_BLE    = 4'd2,
    parameter logic [3:0]      OP_JMP    = 4'd5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    input  logic [INSN_W-1:0] iInstruction,
    output logic [ADDR_W-1:0] oAddress,
    output logic [INSN_W-1:0] oInstruction,
    output logic              oValid,
    input  logic              iStall,
    input  logic              iBranchValid,
    input  logic              iBranchTaken,
    output logic [ADDR_W-1:0] oPC,
    output logic [1:0]        oState
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DELAY  = 2'd2,
        S_BRANCH = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_q;
    logic [INSN_W-1:0] insn_q;
    logic              valid_q;
    logic [23:0]       cnt;
    logic [7:0]        target;

    logic              slot_free;
    logic [3:0]        opcode;
    logic [7:0]        field_a;
    logic [23:0]       imm24;
    logic [ADDR_W-1:0] pc_inc;

    // Decode fields of the ROM word currently addressed by the PC.
    assign opcode    = iInstruction[27:24];
    assign field_a   = iInstruction[23:16];
    assign imm24     = iInstruction[23:0];
    assign slot_free = !valid_q || !iStall;
    // PC arithmetic wraps naturally modulo 2^ADDR_W.
    assign pc_inc    = pc + ADDR_W'(1);

    // Fetch/issue FSM. All outputs are registered here.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pc_q    <= '0;
            insn_q  <= '0;
            valid_q <= 1'b0;
            cnt     <= '0;
            target  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iEnable) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (slot_free) begin
                        if (!iEnable) begin
                            valid_q <= 1'b0;
                            state   <= S_IDLE;
                        end else if (opcode == OP_JMP) begin
                            // Jump costs one bubble and is never seen by execute.
                            valid_q <= 1'b0;
                            pc      <= {{(ADDR_W-8){1'b0}}, field_a};
                        end else if (opcode == OP_NOP) begin
                            valid_q <= 1'b0;
                            pc      <= pc_inc;
                            if (NOP_DELAY && (imm24 != 24'd0)) begin
                                cnt   <= imm24;
                                state <= S_DELAY;
                            end
                        end else begin
                            insn_q  <= iInstruction;
                            pc_q    <= pc;
                            valid_q <= 1'b1;
                            pc      <= pc_inc;
                            if (opcode == OP_BLE) begin
                                target <= field_a;
                                state  <= S_BRANCH;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    // The NOP edge is the first bubble. DELAY then lasts imm24 cycles.
                    cnt <= cnt - 24'd1;
                    if (cnt <= 24'd1) state <= S_ISSUE;
                end
                S_BRANCH: begin
                    // Retire the issued BLE before listening for its resolution.
                    if (valid_q) begin
                        if (!iStall) valid_q <= 1'b0;
                    end else if (iBranchValid) begin
                        if (iBranchTaken) pc <= {{(ADDR_W-8){1'b0}}, target};
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oAddress     = pc;
    assign oInstruction = insn_q;
    assign oValid       = valid_q;
    assign oPC          = pc_q;
    assign oState       = state;

endmodule
